// File: rtl/om_req_arbiter_pkg.sv
// om_req_arbiter_pkg: shared OM request layout, widths and arbiter state encoding
package om_req_arbiter_pkg;
  localparam int OM_NUM_LANES = 4;
  localparam int OM_UUID_W = 44;
  localparam int OM_DIM_BITS = 11;
  localparam int OM_DEPTH_BITS = 24;
  function automatic int om_req_dataw(input int lanes, input int uuid_w, input int dim_bits, input int depth_bits);
    return uuid_w + lanes * (1 + 2 * dim_bits + 32 + depth_bits + 1);
  endfunction
  function automatic int om_tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int OM_REQ_DATAW = om_req_dataw(OM_NUM_LANES, OM_UUID_W, OM_DIM_BITS, OM_DEPTH_BITS);
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} om_state_e;
  typedef struct packed {
    logic [OM_UUID_W-1:0] uuid;
    logic [OM_NUM_LANES-1:0] mask;
    logic [OM_NUM_LANES-1:0][OM_DIM_BITS-1:0] pos_x;
    logic [OM_NUM_LANES-1:0][OM_DIM_BITS-1:0] pos_y;
    logic [OM_NUM_LANES-1:0][31:0] color;
    logic [OM_NUM_LANES-1:0][OM_DEPTH_BITS-1:0] depth;
    logic [OM_NUM_LANES-1:0] face;
  } om_req_t;
endpackage

// File: rtl/om_elastic_buf.sv
// om_elastic_buf: 2-entry skid buffer with registered output; full is the only back-pressure
module om_elastic_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] din,
  output logic             full,
  input  logic             ready,
  output logic             valid,
  output logic [DATAW-1:0] dout
);
  logic             skid_v;
  logic [DATAW-1:0] skid_q;
  assign full = skid_v;
  // head register feeds the output; skid slot holds the entry that arrived while the head stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      skid_v <= 1'b0;
      dout <= '0;
      skid_q <= '0;
    end else if (valid && ready) begin
      if (skid_v) begin
        dout <= skid_q;
        skid_v <= 1'b0;
      end else begin
        valid <= push;
        if (push) dout <= din;
      end
    end else if (push) begin
      if (valid) begin
        skid_q <= din;
        skid_v <= 1'b1;
      end else begin
        dout <= din;
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/om_rr_arbiter.sv
// om_rr_arbiter: combinational round-robin pick of the first valid index at or after ptr
module om_rr_arbiter import om_req_arbiter_pkg::*; #(
  parameter int NUM_REQS = 4,
  localparam int TAG_W = om_tag_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [TAG_W-1:0]    ptr,
  output logic [TAG_W-1:0]    grant,
  output logic [NUM_REQS-1:0] grant_oh,
  output logic                any_valid
);
  logic [TAG_W-1:0] idx;
  // scan from the farthest offset down so the nearest valid index after ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = TAG_W'((int'(ptr) + k) % NUM_REQS);
      grant = valid[idx] ? idx : grant;
    end
  end
  assign any_valid = |valid;
  assign grant_oh = any_valid ? NUM_REQS'(1) << grant : '0;
endmodule

// File: rtl/om_req_arbiter.sv
// om_req_arbiter: round-robin merge of per-core OM request buses onto one tagged OM bus with drain handshake
module om_req_arbiter import om_req_arbiter_pkg::*; #(
  parameter int NUM_REQS = 4,
  parameter int NUM_LANES = OM_NUM_LANES,
  parameter int UUID_W = OM_UUID_W,
  parameter int DIM_BITS = OM_DIM_BITS,
  parameter int DEPTH_BITS = OM_DEPTH_BITS,
  localparam int REQ_DATAW = om_req_dataw(NUM_LANES, UUID_W, DIM_BITS, DEPTH_BITS),
  localparam int TAG_W = om_tag_w(NUM_REQS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid_in,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data_in,
  output logic [NUM_REQS-1:0]           req_ready_in,
  output logic                          req_valid_out,
  output logic [REQ_DATAW-1:0]          req_data_out,
  output logic [TAG_W-1:0]              req_tag_out,
  input  logic                          req_ready_out,
  input  logic                          drain_req,
  output logic                          drain_ack,
  output logic [31:0]                   perf_stalls
);
  om_state_e                    state;
  logic [TAG_W-1:0]             rr_ptr;
  logic [TAG_W-1:0]             grant;
  logic [NUM_REQS-1:0]          grant_oh;
  logic                         any_valid;
  logic                         full;
  logic                         accept;
  logic [REQ_DATAW-1:0]         sel_data;
  logic [TAG_W+REQ_DATAW-1:0]   buf_q;
  om_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_rr (
    .valid(req_valid_in),
    .ptr(rr_ptr),
    .grant(grant),
    .grant_oh(grant_oh),
    .any_valid(any_valid)
  );
  assign accept = reset && state == RUN && !full && any_valid;
  assign req_ready_in = accept ? grant_oh : '0;
  // route the granted agent's payload to the buffer input
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQS; i++)
      sel_data = grant == TAG_W'(i) ? req_data_in[i*REQ_DATAW +: REQ_DATAW] : sel_data;
  end
  om_elastic_buf #(.DATAW(TAG_W + REQ_DATAW)) u_buf (
    .clk(clk),
    .reset(reset),
    .push(accept),
    .din({grant, sel_data}),
    .full(full),
    .ready(req_ready_out),
    .valid(req_valid_out),
    .dout(buf_q)
  );
  assign {req_tag_out, req_data_out} = buf_q;
  // pointer moves just past the winner on every accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else if (accept) rr_ptr <= grant == TAG_W'(NUM_REQS - 1) ? '0 : grant + 1'b1;
  end
  // drain handshake: stop accepting, wait for the buffer to empty, then hold acknowledged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      drain_ack <= 1'b0;
    end else begin
      case (state)
        RUN: if (drain_req) state <= DRAIN;
        DRAIN: begin
          if (!drain_req) state <= RUN;
          else if (!req_valid_out) begin
            state <= DRAINED;
            drain_ack <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state <= RUN;
            drain_ack <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
  // count cycles where some agent is waiting but nothing is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_stalls <= '0;
    else if (any_valid && !accept) perf_stalls <= perf_stalls + 32'd1;
  end
endmodule

// File: tb/tb_om_req_arbiter.sv
// tb_om_req_arbiter: directed and random checks of om_req_arbiter against a queue-based model
module tb_om_req_arbiter;
  import om_req_arbiter_pkg::*;
  localparam int N = 4;
  localparam int DW = OM_REQ_DATAW;
  localparam int TW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid_in = '0;
  logic [N*DW-1:0] req_data_in = '0;
  logic [N-1:0] req_ready_in;
  logic req_valid_out;
  logic [DW-1:0] req_data_out;
  logic [TW-1:0] req_tag_out;
  logic req_ready_out = 1'b0;
  logic drain_req = 1'b0;
  logic drain_ack;
  logic [31:0] perf_stalls;
  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  logic [TW+DW-1:0] mq[$];
  int m_ptr = 0;
  int m_st = 0;
  logic [31:0] m_stalls = '0;
  logic [31:0] s0;
  int exp3[5] = '{1, 2, 0, 0, 0};
  int ack4[4] = '{0, 0, 0, 1};

  om_req_arbiter dut (
    .clk(clk),
    .reset(rst_n),
    .req_valid_in(req_valid_in),
    .req_data_in(req_data_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out),
    .req_data_out(req_data_out),
    .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .drain_req(drain_req),
    .drain_ack(drain_ack),
    .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < N; k++)
      if (req_valid_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g;
    g = m_grant();
    return (rst_n && m_st == 0 && mq.size() < 2 && g >= 0) ? N'(1) << g : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N * DW; i++) req_data_in[i] = 1'($urandom);
  endtask

  task automatic set_uuid(input int a, input int u);
    om_req_t r;
    r = req_data_in[a*DW +: DW];
    r.uuid = OM_UUID_W'(u);
    req_data_in[a*DW +: DW] = r;
  endtask

  // reference model: a FIFO of accepted requests, pointer and drain state advanced per edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ptr = 0;
      m_st = 0;
      m_stalls = '0;
    end else begin
      int g;
      bit acc, pop, emp;
      g = m_grant();
      acc = m_ready() != '0;
      pop = mq.size() > 0 && req_ready_out;
      emp = mq.size() == 0;
      if (req_valid_in != '0 && !acc) m_stalls = m_stalls + 32'd1;
      if (m_st == 0) m_st = drain_req ? 1 : 0;
      else if (m_st == 1) m_st = !drain_req ? 0 : (emp ? 2 : 1);
      else m_st = drain_req ? 2 : 0;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({TW'(g), req_data_in[g*DW +: DW]});
        m_ptr = (g + 1) % N;
      end
    end
  end

  // per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid_out", 512'(req_valid_out), 512'(mq.size() > 0));
      chk("ready_in", 512'(req_ready_in), 512'(m_ready()));
      chk("drain_ack", 512'(drain_ack), 512'(m_st == 2));
      chk("perf_stalls", 512'(perf_stalls), 512'(m_stalls));
      if (mq.size() > 0) begin
        chk("tag", 512'(req_tag_out), 512'(mq[0][TW+DW-1 -: TW]));
        chk("data", 512'(req_data_out), 512'(mq[0][DW-1:0]));
      end
    end
  end

  initial begin
    rand_data();
    req_valid_in = '1;
    chk_en = 1'b1;
    mid();
    chk("rst_valid_out", 512'(req_valid_out), 512'(0));
    chk("rst_ready_in", 512'(req_ready_in), 512'(0));
    chk("rst_drain_ack", 512'(drain_ack), 512'(0));
    chk("rst_perf_stalls", 512'(perf_stalls), 512'(0));
    tick();
    req_valid_in = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    // all agents valid, output always ready: tags rotate one per cycle
    tick();
    req_valid_in = '1;
    req_ready_out = 1'b1;
    mid();
    chk("t1_latency", 512'(req_valid_out), 512'(0));
    chk("t1_first_ready", 512'(req_ready_in), 512'(4'b0001));
    for (int k = 0; k < 6; k++) begin
      tick();
      mid();
      chk("t1_tag", 512'(req_tag_out), 512'(k % 4));
      chk("t1_valid", 512'(req_valid_out), 512'(1));
    end
    // single agent 2 streaming uuids 5,6,7
    tick();
    req_valid_in = 4'b0100;
    for (int u = 5; u <= 7; u++) begin
      set_uuid(2, u);
      mid();
      chk("t2_ready", 512'(req_ready_in), 512'(4'b0100));
      if (u > 5) begin
        chk("t2_uuid", 512'(req_data_out[DW-1 -: OM_UUID_W]), 512'(u - 1));
        chk("t2_tag", 512'(req_tag_out), 512'(2));
      end
      tick();
    end
    req_valid_in = '0;
    mid();
    chk("t2_last_uuid", 512'(req_data_out[DW-1 -: OM_UUID_W]), 512'(7));
    chk("t2_last_tag", 512'(req_tag_out), 512'(2));
    // output stalled: two accepts fill the buffer, then everything blocks
    tick();
    req_valid_in = 4'b0011;
    req_ready_out = 1'b0;
    mid();
    s0 = m_stalls;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) mid();
      chk("t3_ready", 512'(req_ready_in), 512'(exp3[k]));
      tick();
    end
    req_ready_out = 1'b1;
    mid();
    chk("t3_stalls_3", 512'(perf_stalls), 512'(s0 + 32'd3));
    chk("t3_blocked_full", 512'(req_ready_in), 512'(0));
    chk("t3_head_tag", 512'(req_tag_out), 512'(0));
    tick();
    mid();
    chk("t3_resume", 512'(req_ready_in), 512'(4'b0001));
    chk("t3_stalls_4", 512'(perf_stalls), 512'(s0 + 32'd4));
    // drain with two entries buffered
    tick();
    req_valid_in = '0;
    tick();
    req_valid_in = 4'b0011;
    req_ready_out = 1'b0;
    tick();
    tick();
    drain_req = 1'b1;
    req_ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      mid();
      chk("t4_ack", 512'(drain_ack), 512'(ack4[k]));
      chk("t4_no_accept", 512'(req_ready_in), 512'(0));
    end
    tick();
    drain_req = 1'b0;
    mid();
    chk("t4_ack_hold", 512'(drain_ack), 512'(1));
    chk("t4_frozen", 512'(req_ready_in), 512'(0));
    tick();
    mid();
    chk("t4_ack_fall", 512'(drain_ack), 512'(0));
    chk("t4_resume", 512'(req_ready_in), 512'(4'b0010));
    // drain with empty buffer, then an aborted drain
    tick();
    req_valid_in = '0;
    tick();
    tick();
    tick();
    drain_req = 1'b1;
    mid();
    chk("t5_ack_e0", 512'(drain_ack), 512'(0));
    tick();
    mid();
    chk("t5_ack_e1", 512'(drain_ack), 512'(0));
    tick();
    mid();
    chk("t5_ack_e2", 512'(drain_ack), 512'(1));
    tick();
    drain_req = 1'b0;
    tick();
    drain_req = 1'b1;
    mid();
    chk("t5_abort_run", 512'(drain_ack), 512'(0));
    tick();
    drain_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t5_abort_ack", 512'(drain_ack), 512'(0));
      tick();
    end
    // asynchronous reset with a full buffer
    req_valid_in = '1;
    req_ready_out = 1'b0;
    tick();
    tick();
    tick();
    mid();
    chk("t6_full_valid", 512'(req_valid_out), 512'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 512'(req_valid_out), 512'(0));
    chk("t6_async_ready", 512'(req_ready_in), 512'(0));
    chk("t6_async_stalls", 512'(perf_stalls), 512'(0));
    tick();
    req_valid_in = 4'b0110;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_first_grant", 512'(req_ready_in), 512'(4'b0010));
    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      req_valid_in = N'($urandom);
      req_ready_out = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      rand_data();
    end
    mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
